// File: rtl/whac_pkg.sv
// Shared definitions for the whac-a-mole round logic: round state encoding,
// default board/combo sizes and a popcount helper.
package whac_pkg;

  localparam int NUM_HOLES_DFLT = 18;
  localparam int COMBO_MAX_DFLT = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    UP   = 2'd2,
    GAP  = 2'd3
  } round_state_e;

  // Operates on a zero-extended 64-bit vector so any board up to 64 holes fits.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS clocks, restartable
// with a synchronous clear so the next tick is a full period away.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick depends only on the counter, never on clr, so clr may be derived from tick.
  assign tick = (cnt_q == CNT_W'(CLKS_PER_MS - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// Round sequencer for the mole game: request pattern, adaptive mole-up window,
// whack detection, hit/miss/combo reporting. Optional macro: WHACK_PENALTY_EN.
module mole_round_scheduler
  import whac_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000,
  parameter int NUM_HOLES   = NUM_HOLES_DFLT,
  parameter int UP_MS_START = 1000,
  parameter int UP_MS_MIN   = 300,
  parameter int UP_MS_STEP  = 50,
  parameter int GAP_MS      = 200,
  parameter int COMBO_MAX   = COMBO_MAX_DFLT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               game_in_progress,
  input  logic [NUM_HOLES-1:0]               sw_in,
  input  logic [NUM_HOLES-1:0]               gen_positions,
  input  logic                               gen_valid,
  output logic                               gen_req,
  output logic [NUM_HOLES-1:0]               mole_leds,
  output logic                               mole_up_window,
  output logic                               hit_pulse,
  output logic [$clog2(NUM_HOLES+1)-1:0]     hit_num,
  output logic                               miss_pulse,
  output logic [$clog2(NUM_HOLES+1)-1:0]     miss_num,
  output logic [$clog2(COMBO_MAX+1)-1:0]     combo_count,
  output logic [$clog2(UP_MS_START+1)-1:0]   up_ms
`ifdef WHACK_PENALTY_EN
  ,
  output logic                               wrong_pulse
`endif
);

  localparam int HNW    = $clog2(NUM_HOLES + 1);
  localparam int CW     = $clog2(COMBO_MAX + 1);
  localparam int UPW    = $clog2(UP_MS_START + 1);
  localparam int MS_MAX = (UP_MS_START > GAP_MS) ? UP_MS_START : GAP_MS;
  localparam int MSW    = $clog2(MS_MAX + 1);

  round_state_e         state_q, state_d;
  logic [NUM_HOLES-1:0] mask_q, mask_d;
  logic [NUM_HOLES-1:0] sw_prev_q;
  logic [MSW-1:0]       ms_cnt_q, ms_cnt_d;
  logic [CW-1:0]        combo_q, combo_d;
  logic [UPW-1:0]       up_ms_q, up_ms_d;
  logic                 gen_req_q, gen_req_d;
  logic [NUM_HOLES-1:0] mole_leds_q, mole_leds_d;
  logic                 window_q, window_d;
  logic                 hit_q, hit_d;
  logic [HNW-1:0]       hit_num_q, hit_num_d;
  logic                 miss_q, miss_d;
  logic [HNW-1:0]       miss_num_q, miss_num_d;
`ifdef WHACK_PENALTY_EN
  logic                 wrong_q, wrong_d;
  logic [NUM_HOLES-1:0] wrong;
`endif

  logic [NUM_HOLES-1:0] rise, hits, remaining;
  logic                 tick, tick_clr;

  // Restart the millisecond base on every state entry so each window starts whole.
  assign tick_clr = (state_d != state_q);

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_ms_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ms_cnt_d   = ms_cnt_q;
    combo_d    = combo_q;
    up_ms_d    = up_ms_q;
    hit_d      = 1'b0;
    hit_num_d  = '0;
    miss_d     = 1'b0;
    miss_num_d = '0;
    rise       = sw_in & ~sw_prev_q;
    hits       = mask_q & rise;
    remaining  = mask_q & ~hits;
`ifdef WHACK_PENALTY_EN
    wrong_d    = 1'b0;
    wrong      = rise & ~mask_q;
`endif

    if (!game_in_progress) begin
      state_d  = IDLE;
      mask_d   = '0;
      ms_cnt_d = '0;
      combo_d  = '0;
      up_ms_d  = UPW'(UP_MS_START);
    end else begin
      unique case (state_q)
        IDLE: begin
          combo_d = '0;
          up_ms_d = UPW'(UP_MS_START);
          state_d = REQ;
        end
        REQ: begin
          if (gen_valid && (|gen_positions)) begin
            mask_d   = gen_positions;
            ms_cnt_d = MSW'(up_ms_q);
            state_d  = UP;
          end
        end
        UP: begin
          if (|hits) begin
            hit_d     = 1'b1;
            hit_num_d = HNW'(popcount(64'(hits)));
            mask_d    = remaining;
          end
          // A clearing hit wins over a coincident timeout.
          if (remaining == '0) begin
            state_d  = GAP;
            ms_cnt_d = MSW'(GAP_MS);
            combo_d  = (combo_q == CW'(COMBO_MAX)) ? combo_q : combo_q + CW'(1);
            up_ms_d  = (32'(up_ms_q) >= 32'(UP_MS_MIN + UP_MS_STEP)) ?
                       up_ms_q - UPW'(UP_MS_STEP) : UPW'(UP_MS_MIN);
          end else if (tick) begin
            if (ms_cnt_q == MSW'(1)) begin
              miss_d     = 1'b1;
              miss_num_d = HNW'(popcount(64'(remaining)));
              combo_d    = '0;
              mask_d     = '0;
              state_d    = GAP;
              ms_cnt_d   = MSW'(GAP_MS);
            end else begin
              ms_cnt_d = ms_cnt_q - MSW'(1);
            end
          end
`ifdef WHACK_PENALTY_EN
          if (|wrong) begin
            wrong_d = 1'b1;
            combo_d = '0;
          end
`endif
        end
        GAP: begin
          if (tick) begin
            if (ms_cnt_q <= MSW'(1)) begin
              state_d = REQ;
            end else begin
              ms_cnt_d = ms_cnt_q - MSW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    gen_req_d   = (state_d == REQ);
    window_d    = (state_d == UP);
    mole_leds_d = (state_d == UP) ? mask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      sw_prev_q   <= '0;
      ms_cnt_q    <= '0;
      combo_q     <= '0;
      up_ms_q     <= UPW'(UP_MS_START);
      gen_req_q   <= 1'b0;
      mole_leds_q <= '0;
      window_q    <= 1'b0;
      hit_q       <= 1'b0;
      hit_num_q   <= '0;
      miss_q      <= 1'b0;
      miss_num_q  <= '0;
`ifdef WHACK_PENALTY_EN
      wrong_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sw_prev_q   <= sw_in;
      ms_cnt_q    <= ms_cnt_d;
      combo_q     <= combo_d;
      up_ms_q     <= up_ms_d;
      gen_req_q   <= gen_req_d;
      mole_leds_q <= mole_leds_d;
      window_q    <= window_d;
      hit_q       <= hit_d;
      hit_num_q   <= hit_num_d;
      miss_q      <= miss_d;
      miss_num_q  <= miss_num_d;
`ifdef WHACK_PENALTY_EN
      wrong_q     <= wrong_d;
`endif
    end
  end

  assign gen_req        = gen_req_q;
  assign mole_leds      = mole_leds_q;
  assign mole_up_window = window_q;
  assign hit_pulse      = hit_q;
  assign hit_num        = hit_num_q;
  assign miss_pulse     = miss_q;
  assign miss_num       = miss_num_q;
  assign combo_count    = combo_q;
  assign up_ms          = up_ms_q;
`ifdef WHACK_PENALTY_EN
  assign wrong_pulse    = wrong_q;
`endif

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Sequences the mole generator round by round during a game.
- Each round: requests a new mole pattern, holds the mole-up window for an adaptive number of milliseconds, detects whacks from debounced switches, and emits hit/miss events and a combo count to the score counter.
- Sits between the game FSM (game_in_progress), the mole generator, the debounced SW bus and the score counter.
- Replaces ad-hoc window timing inside the FSM.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick.
- NUM_HOLES, 18, number of holes (switch/LED bits).
- UP_MS_START, 1000, initial mole-up window in ms.
- UP_MS_MIN, 300, floor of the mole-up window in ms.
- UP_MS_STEP, 50, window reduction per cleared round.
- GAP_MS, 200, blank time between rounds in ms.
- COMBO_MAX, 99, combo saturation value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- game_in_progress  in  1  high while the game timer runs.
- sw_in  in  NUM_HOLES  debounced switch levels.
- gen_positions  in  NUM_HOLES  mole pattern from the generator.
- gen_valid  in  1  one-cycle strobe; gen_positions is valid.
- gen_req  out  1  request a new pattern; held until gen_valid.
- mole_leds  out  NUM_HOLES  moles currently up.
- mole_up_window  out  1  high in the UP state.
- hit_pulse  out  1  one-cycle strobe; at least one mole hit.
- hit_num  out  $clog2(NUM_HOLES+1)  number of moles hit this cycle.
- miss_pulse  out  1  one-cycle strobe at timeout with moles remaining.
- miss_num  out  $clog2(NUM_HOLES+1)  number of moles left at timeout.
- combo_count  out  $clog2(COMBO_MAX+1)  consecutive cleared rounds.
- up_ms  out  $clog2(UP_MS_START+1)  current window length.

Behaviour:
- Reset (rst_n=0 at clk edge), all outputs 0 except up_ms=UP_MS_START:
  - state=IDLE, active mask=0, sw_prev=0, both counters cleared.
- Prescaler: tick every CLKS_PER_MS cycles. It is cleared on every state entry, so the first ms of every window is a full ms.
- sw_prev <= sw_in every cycle in every state. rise = sw_in & ~sw_prev.
- States:
  - IDLE:
    - Outputs low; up_ms=UP_MS_START; combo=0.
    - game_in_progress=1 -> REQ next cycle.
  - REQ:
    - gen_req=1.
    - On gen_valid with nonzero gen_positions: latch mask, ms_cnt<=up_ms, -> UP.
    - On gen_valid with zero positions: stay in REQ and re-request; gen_req stays high.
  - UP:
    - mole_leds=mask; mole_up_window=1.
    - hits = mask & rise. If nonzero: hit_pulse=1, hit_num=popcount(hits), mask <= mask & ~hits (registered; effective next cycle).
    - Cleared round: if the mask would become 0, go to GAP. combo+1 (saturate at COMBO_MAX). up_ms = max(up_ms-UP_MS_STEP, UP_MS_MIN).
    - Timeout: on a tick with ms_cnt==1 and moles remaining, miss_pulse=1, miss_num=popcount(remaining after hits), combo<=0, up_ms unchanged, -> GAP.
    - Hit and timeout in the same cycle: the hit is processed first. If that hit clears the round, it is treated as cleared with no miss. Otherwise both hit_pulse and miss_pulse fire in that cycle.
  - GAP:
    - mole_leds=0.
    - After GAP_MS ticks -> REQ.
- game_in_progress=0 in any state -> IDLE next cycle.
  - Mask, combo and gen_req are cleared. up_ms resets to UP_MS_START.
  - No hit or miss pulse in the cycle the drop is seen.
- Rises of switches outside the mask are ignored. Rises outside UP are ignored.
- Reset mid-round aborts the round; no pulses are emitted.
- Output latency: all outputs are registered; pulses occur one cycle after the causing rise or tick.

Optional Feature:
- Macro: WHACK_PENALTY_EN.
- Defined:
  - Adds output wrong_pulse (1 bit).
  - In UP, any rise on a hole outside the mask asserts wrong_pulse for one cycle and clears combo_count to 0.
  - The window and mask are unaffected.
  - A cycle with both valid and wrong rises gives hit_pulse and wrong_pulse together; combo is cleared, and a round cleared in that cycle does not increment combo.
- Undefined: no wrong_pulse port; off-mask rises are ignored.

Decomposition:
- Shared package whac_pkg:
  - State encoding (IDLE, REQ, UP, GAP; 2 bits).
  - NUM_HOLES and COMBO_MAX constants.
  - popcount function.
- Sub-module ms_tick_gen (CLKS_PER_MS prescaler with sync clear); reusable by the game timer.

Test Plan:
- Test parameters: CLKS_PER_MS=5, UP_MS_START=4, UP_MS_MIN=2, UP_MS_STEP=1, GAP_MS=2.
- Reset/start: game_in_progress=1 after reset -> gen_req=1; gen_valid with 0x00300 -> mole_leds=0x00300, mole_up_window=1, up_ms=4.
- Hits: rise SW[8], then later SW[9] -> two hit_pulses with hit_num=1 each. After the second: GAP, combo=1, up_ms=3, leds 0 for 10 cycles, then gen_req=1.
- Timeout: mask 0x04020, only SW[5] rises -> after 4 ms, miss_pulse with miss_num=1, combo=0, up_ms unchanged.
- Simultaneous: SW[14] rises on the final tick while it is the last mole -> hit_pulse, no miss_pulse, combo increments.
- Floor/saturation: clear 5 rounds -> up_ms sequence 4,3,2,2,2. Force combo past COMBO_MAX -> holds at 99.
- Abort: drop game_in_progress mid-UP -> IDLE next cycle, leds=0, combo=0, up_ms=4, no pulses. Zero gen_positions -> gen_req stays high.
